button_array_cntr: RTL and testbench

//  Parametrised N-channel push-button front end for the clock/watch UI: synchronises raw pad inputs,

---
 rtl/button_array_cntr.sv | 178 +++++++++++++++++
 tb/tb_button_array_cntr.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_array_cntr.sv
// button_array_cntr: N-channel push-button front end (sync, debounce, press/release/long/repeat pulses).
// Latency: 2 clk synchroniser + DB_SAMPLES sample ticks to btn_level/btn_pe/btn_ne; all outputs registered.
// Backpressure: none; pulses are single-cycle strobes that the consumer must sample every clk.
// Ports: clk, reset_n (sync, active-low), btn[N_BTN] raw pads in;
//        btn_level, btn_pe, btn_ne, btn_long, btn_rpt [N_BTN] out, all clk-domain.
module button_array_cntr #(
  parameter int N_BTN          = 4,
  parameter int TICK_DIV       = 100000,
  parameter int DB_SAMPLES     = 4,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pe,
  output logic [N_BTN-1:0] btn_ne,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_rpt
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DBW = $clog2(DB_SAMPLES + 1);
  localparam int HW  = $clog2(LONG_TICKS + 1);
  localparam int RW  = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_SAMPLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [RW-1:0]  RPT_LAST  = RW'((REPEAT_TICKS > 0) ? (REPEAT_TICKS - 1) : 0);
  localparam bit             RPT_EN    = (REPEAT_TICKS > 0);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} hold_st_t;

  // Polarity is normalised before the synchroniser so everything downstream sees 1 = pressed.
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;

  assign btn_in = BTN_ACTIVE_LOW ? ~btn : btn;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  // Shared sample tick: high for the single clk where the divider sits at its terminal count.
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic           lvl_q, lvl_d;
    logic           pe_q, pe_d;
    logic           ne_q, ne_d;
    logic           long_q, long_d;
    logic           rpt_q, rpt_d;
    logic [DBW-1:0] db_q, db_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [RW-1:0]  rc_q, rc_d;
    hold_st_t       st_q, st_d;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        lvl_q  <= 1'b0;
        pe_q   <= 1'b0;
        ne_q   <= 1'b0;
        long_q <= 1'b0;
        rpt_q  <= 1'b0;
        db_q   <= '0;
        hold_q <= '0;
        rc_q   <= '0;
        st_q   <= ST_IDLE;
      end else begin
        lvl_q  <= lvl_d;
        pe_q   <= pe_d;
        ne_q   <= ne_d;
        long_q <= long_d;
        rpt_q  <= rpt_d;
        db_q   <= db_d;
        hold_q <= hold_d;
        rc_q   <= rc_d;
        st_q   <= st_d;
      end
    end

    always_comb begin
      lvl_d  = lvl_q;
      pe_d   = 1'b0;
      ne_d   = 1'b0;
      long_d = 1'b0;
      rpt_d  = 1'b0;
      db_d   = db_q;
      hold_d = hold_q;
      rc_d   = rc_q;
      st_d   = st_q;

      // Debounce: a run of differing tick samples flips the level; any agreeing sample restarts the run.
      if (tick) begin
        if (sync_q2[i] != lvl_q) begin
          if (db_q == DB_LAST) begin
            lvl_d = ~lvl_q;
            db_d  = '0;
            pe_d  = ~lvl_q;
            ne_d  = lvl_q;
          end else begin
            db_d = db_q + 1'b1;
          end
        end else begin
          db_d = '0;
        end
      end

      // Hold tracking. A release overrides everything so no long/repeat pulse shares a cycle with btn_ne.
      if (ne_d) begin
        st_d   = ST_IDLE;
        hold_d = '0;
        rc_d   = '0;
      end else begin
        case (st_q)
          ST_IDLE: begin
            hold_d = '0;
            rc_d   = '0;
            if (pe_d) st_d = ST_HELD;
          end
          ST_HELD: begin
            if (tick) begin
              if (hold_q == HOLD_LAST) begin
                hold_d = HOLD_MAX;
                long_d = 1'b1;
                st_d   = ST_LONG;
              end else begin
                hold_d = hold_q + 1'b1;
              end
            end
          end
          ST_LONG: begin
            if (tick && RPT_EN) begin
              if (rc_q == RPT_LAST) begin
                rc_d  = '0;
                rpt_d = 1'b1;
              end else begin
                rc_d = rc_q + 1'b1;
              end
            end
          end
          default: st_d = ST_IDLE;
        endcase
      end
    end

    assign btn_level[i] = lvl_q;
    assign btn_pe[i]    = pe_q;
    assign btn_ne[i]    = ne_q;
    assign btn_long[i]  = long_q;
    assign btn_rpt[i]   = rpt_q;
  end

endmodule

// File: tb/tb_button_array_cntr.sv
// Bench for button_array_cntr: three builds (repeat=2, repeat disabled, active-low pads)
// driven by directed scenarios then randomized hold/release timing, checked every clk
// against an arithmetic reference model plus directed timing/count checks.
module tb_button_array_cntr;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int LT = 5;
  localparam int RT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [1:0] btn_m, btn_n, btn_a;
  logic [1:0] lv_m, pe_m, ne_m, lg_m, rp_m;
  logic [1:0] lv_n, pe_n, ne_n, lg_n, rp_n;
  logic [1:0] lv_a, pe_a, ne_a, lg_a, rp_a;

  button_array_cntr #(.N_BTN(2), .TICK_DIV(TD), .DB_SAMPLES(DB), .LONG_TICKS(LT),
                      .REPEAT_TICKS(RT), .BTN_ACTIVE_LOW(1'b0)) dut_m (
    .clk(clk), .reset_n(reset_n), .btn(btn_m), .btn_level(lv_m), .btn_pe(pe_m),
    .btn_ne(ne_m), .btn_long(lg_m), .btn_rpt(rp_m));

  button_array_cntr #(.N_BTN(2), .TICK_DIV(TD), .DB_SAMPLES(DB), .LONG_TICKS(LT),
                      .REPEAT_TICKS(0), .BTN_ACTIVE_LOW(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n), .btn(btn_n), .btn_level(lv_n), .btn_pe(pe_n),
    .btn_ne(ne_n), .btn_long(lg_n), .btn_rpt(rp_n));

  button_array_cntr #(.N_BTN(2), .TICK_DIV(TD), .DB_SAMPLES(DB), .LONG_TICKS(LT),
                      .REPEAT_TICKS(RT), .BTN_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .btn(btn_a), .btn_level(lv_a), .btn_pe(pe_a),
    .btn_ne(ne_a), .btn_long(lg_a), .btn_rpt(rp_a));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: channels 0-1 main build, 2-3 no-repeat build, 4-5 active-low build.
  logic [5:0] m_s1, m_s2;
  logic [5:0] e_lv, e_pe, e_ne, e_lg, e_rp;
  int         m_run[6];
  int         m_held[6];
  int         m_cyc;

  function automatic int rpt_of(input int c);
    return (c == 2 || c == 3) ? 0 : RT;
  endfunction

  function automatic logic pressed_of(input int c);
    if (c < 2)      return btn_m[c];
    else if (c < 4) return btn_n[c-2];
    else            return ~btn_a[c-4];
  endfunction

  task automatic model_update();
    logic tick;
    logic samp;
    logic was;
    if (!reset_n) begin
      m_cyc = 0;
      m_s1 = '0; m_s2 = '0;
      e_lv = '0; e_pe = '0; e_ne = '0; e_lg = '0; e_rp = '0;
      for (int c = 0; c < 6; c++) begin
        m_run[c]  = 0;
        m_held[c] = 0;
      end
    end else begin
      tick = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      e_pe = '0; e_ne = '0; e_lg = '0; e_rp = '0;
      for (int c = 0; c < 6; c++) begin
        samp = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = pressed_of(c);
        if (tick) begin
          was = e_lv[c];
          if (samp != was) begin
            m_run[c]++;
            if (m_run[c] == DB) begin
              e_lv[c] = ~was;
              m_run[c] = 0;
              if (was) e_ne[c] = 1'b1;
              else     e_pe[c] = 1'b1;
            end
          end else begin
            m_run[c] = 0;
          end
          if (was && e_lv[c]) begin
            m_held[c]++;
            if (m_held[c] == LT) e_lg[c] = 1'b1;
            if (rpt_of(c) > 0 && m_held[c] > LT && ((m_held[c] - LT) % rpt_of(c)) == 0)
              e_rp[c] = 1'b1;
          end
          if (!e_lv[c]) m_held[c] = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    check("lv_m", lv_m, e_lv[1:0]); check("pe_m", pe_m, e_pe[1:0]); check("ne_m", ne_m, e_ne[1:0]);
    check("lg_m", lg_m, e_lg[1:0]); check("rp_m", rp_m, e_rp[1:0]);
    check("lv_n", lv_n, e_lv[3:2]); check("pe_n", pe_n, e_pe[3:2]); check("ne_n", ne_n, e_ne[3:2]);
    check("lg_n", lg_n, e_lg[3:2]); check("rp_n", rp_n, e_rp[3:2]);
    check("lv_a", lv_a, e_lv[5:4]); check("pe_a", pe_a, e_pe[5:4]); check("ne_a", ne_a, e_ne[5:4]);
    check("lg_a", lg_a, e_lg[5:4]); check("rp_a", rp_a, e_rp[5:4]);
  endtask

  initial begin
    int cnt, other, lat, n_pe, n_ne, n_lg, n_rp, n_pa, seen;
    int t_pe, t_lg, t_r1, t_r2;
    int tmr[6];
    logic [5:0] rb;

    // 1: button held through reset is ignored until debounced afterwards
    reset_n = 1'b0; btn_m = 2'b11; btn_n = 2'b00; btn_a = 2'b11;
    repeat (10) cyc();
    check("t1_rst_out_m", {lv_m, pe_m, ne_m, lg_m, rp_m}, 0);
    check("t1_rst_out_a", {lv_a, pe_a, ne_a, lg_a, rp_a}, 0);
    reset_n = 1'b1;
    cnt = 0; other = 0; lat = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (pe_m == 2'b11) begin
        cnt++;
        if (lat < 0) lat = k;
      end else if (pe_m != 2'b00) other++;
    end
    check("t1_pe_once", cnt, 1);
    check("t1_pe_other", other, 0);
    check("t1_pe_latency_ok", (lat >= 1 && lat <= 2 + DB*TD + TD), 1);
    check("t1_level", lv_m, 2'b11);
    btn_m = 2'b00;
    repeat (30) cyc();
    check("t1_released", lv_m, 2'b00);

    // 2: bouncing input never debounces, then one clean press
    n_pe = 0; n_ne = 0;
    for (int k = 0; k < 40; k++) begin
      btn_m[0] = ((k / 3) % 2) == 0;
      cyc();
      if (pe_m[0]) n_pe++;
      if (ne_m[0]) n_ne++;
    end
    check("t2_bounce_pe", n_pe, 0);
    btn_m[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (pe_m[0]) n_pe++;
      if (ne_m[0]) n_ne++;
    end
    check("t2_single_pe", n_pe, 1);
    check("t2_no_ne", n_ne, 0);
    btn_m[0] = 1'b0;
    repeat (30) cyc();

    // 3: long press then auto-repeat, release stops repeats
    t_pe = -1; t_lg = -1; t_r1 = -1; t_r2 = -1;
    btn_m[0] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (pe_m[0] && t_pe < 0) t_pe = k;
      if (lg_m[0] && t_lg < 0) t_lg = k;
      if (rp_m[0]) begin
        if (t_r1 < 0) t_r1 = k;
        else if (t_r2 < 0) t_r2 = k;
      end
    end
    check("t3_pe_seen", (t_pe >= 0), 1);
    check("t3_long_gap", t_lg - t_pe, LT*TD);
    check("t3_rpt1_gap", t_r1 - t_lg, RT*TD);
    check("t3_rpt2_gap", t_r2 - t_r1, RT*TD);
    btn_m[0] = 1'b0;
    n_ne = 0; n_rp = 0; seen = 0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (ne_m[0]) begin n_ne++; seen = 1; end
      else if (seen != 0 && rp_m[0]) n_rp++;
    end
    check("t3_one_ne", n_ne, 1);
    check("t3_no_rpt_after_ne", n_rp, 0);

    // 4: short press on channel 1 gives pe and ne but no long
    n_pe = 0; n_ne = 0; n_lg = 0;
    for (int k = 0; k < 60; k++) begin
      btn_m[1] = (k < 16);
      cyc();
      if (pe_m[1]) n_pe++;
      if (ne_m[1]) n_ne++;
      if (lg_m[1]) n_lg++;
    end
    check("t4_pe", n_pe, 1);
    check("t4_ne", n_ne, 1);
    check("t4_no_long", n_lg, 0);

    // 5: repeat-disabled build and active-low build
    n_lg = 0; n_rp = 0; n_pa = 0; n_ne = 0;
    for (int k = 0; k < 120; k++) begin
      btn_n[0] = (k < 80);
      btn_a[0] = (k < 30) ? 1'b0 : 1'b1;
      cyc();
      if (lg_n[0]) n_lg++;
      if (rp_n[0]) n_rp++;
      if (pe_a[0]) n_pa++;
      if (ne_a[0]) n_ne++;
    end
    check("t5_nr_long", n_lg, 1);
    check("t5_nr_no_rpt", n_rp, 0);
    check("t5_al_pe", n_pa, 1);
    check("t5_al_ne", n_ne, 1);

    // 6: reset while in long-press state, then re-press timing
    btn_m[0] = 1'b1;
    seen = 0;
    for (int k = 0; k < 60 && seen == 0; k++) begin
      cyc();
      if (lg_m[0]) seen = 1;
    end
    check("t6_long_seen", seen, 1);
    repeat (3) cyc();
    reset_n = 1'b0;
    cyc();
    check("t6_rst_out", {lv_m, pe_m, ne_m, lg_m, rp_m}, 0);
    reset_n = 1'b1;
    t_pe = -1; t_lg = -1;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (pe_m[0] && t_pe < 0) t_pe = k;
      if (lg_m[0] && t_lg < 0) t_lg = k;
    end
    check("t6_new_pe", (t_pe >= 0 && t_pe <= 2 + DB*TD + TD), 1);
    check("t6_long_gap", t_lg - t_pe, LT*TD);
    btn_m = 2'b00;
    repeat (30) cyc();

    // Randomized hold/release durations on all channels with occasional reset
    rb = {~btn_a, btn_n, btn_m};
    for (int c = 0; c < 6; c++) tmr[c] = $urandom_range(1, 40);
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < 6; c++) begin
        tmr[c]--;
        if (tmr[c] <= 0) begin
          rb[c] = ~rb[c];
          tmr[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 90);
        end
      end
      btn_m = rb[1:0];
      btn_n = rb[3:2];
      btn_a = ~rb[5:4];
      reset_n = ($urandom_range(0, 799) != 0);
      cyc();
    end
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
